// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MAR/MDR memory access unit with a DEPTH x DATA_W RAM and a
//               programmable number of wait states per load/store.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] BusMuxOut,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic [ADDR_W-1:0] mar_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      c_wait  = 3'(WAIT_STATES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic              r_op_wr;
    logic              w_op_wr_nxt;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_done;
    logic              r_err;
    logic              w_idle;
    logic              w_conflict;
    logic              w_complete;
    logic              w_in_range;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_rd_data;

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_idle     = (r_state == IDLE);
    assign w_in_range = ({1'b0, r_mar} < c_depth);
    assign w_mem_we   = w_complete & r_op_wr & w_in_range;
    assign w_rd_data  = w_in_range ? r_mem[r_mar] : '0;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_op_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op_wr <= w_op_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_wr_nxt = r_op_wr;
        w_conflict  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (Read && Write) begin
                    w_conflict = 1'b1;
                end else if (Read || Write) begin
                    w_op_wr_nxt = Write;
                    w_cnt_nxt   = c_wait;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // MAR/MDR only accept bus loads while idle; a read completion owns MDR
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_mar  <= '0;
            r_mdr  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_complete;
            r_err  <= w_conflict | (w_complete & ~w_in_range);
            if (w_idle && MARin) begin
                r_mar <= BusMuxOut[ADDR_W-1:0];
            end
            if (w_complete && !r_op_wr) begin
                r_mdr <= w_rd_data;
            end else if (w_idle && MDRin) begin
                r_mdr <= BusMuxOut;
            end
        end
    end

    // RAM contents are deliberately outside the reset domain
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_mar] <= r_mdr;
        end
    end

    assign BusMuxInMDR = r_mdr;
    assign mar_q       = r_mar;
    assign busy        = ~w_idle;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed and randomized bench for two mem_access_unit builds
//               (no wait states / 512 words, three wait states / 500 words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic             clock = 1'b0;
    logic             clear;
    logic [1:0]       marin;
    logic [1:0]       mdrin;
    logic [1:0]       rd;
    logic [1:0]       wr;
    logic [1:0][31:0] bus;
    logic [1:0][31:0] mdr_o;
    logic [1:0][8:0]  mar_o;
    logic [1:0]       busy_o;
    logic [1:0]       done_o;
    logic [1:0]       err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .clear(clear), .MARin(marin[0]), .MDRin(mdrin[0]),
        .Read(rd[0]), .Write(wr[0]), .BusMuxOut(bus[0]), .BusMuxInMDR(mdr_o[0]),
        .mar_q(mar_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    mem_access_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(500), .WAIT_STATES(3)) u_dut1 (
        .clock(clock), .clear(clear), .MARin(marin[1]), .MDRin(mdrin[1]),
        .Read(rd[1]), .Write(wr[1]), .BusMuxOut(bus[1]), .BusMuxInMDR(mdr_o[1]),
        .mar_q(mar_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    // Transaction-level reference: registers, memory image, cycles left in the access
    int          c_ws  [2] = '{0, 3};
    int          c_dep [2] = '{512, 500};
    logic [31:0] m_mem  [2][512];
    bit          m_memk [2][512];
    logic [8:0]  m_mar  [2];
    logic [31:0] m_mdr  [2];
    bit          m_mdrk [2];
    int          m_rem  [2];
    bit          m_wr   [2];
    bit          m_done [2];
    bit          m_err  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_mar[k]  = '0;
        m_mdr[k]  = '0;
        m_mdrk[k] = 1'b1;
        m_rem[k]  = -1;
        m_done[k] = 1'b0;
        m_err[k]  = 1'b0;
    endtask

    task automatic model_edge(input int k);
        m_done[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (m_rem[k] > 0) begin
            m_rem[k]--;
        end else if (m_rem[k] == 0) begin
            if (int'(m_mar[k]) < c_dep[k]) begin
                if (m_wr[k]) begin
                    m_mem[k][m_mar[k]]  = m_mdr[k];
                    m_memk[k][m_mar[k]] = m_mdrk[k];
                end else begin
                    m_mdr[k]  = m_mem[k][m_mar[k]];
                    m_mdrk[k] = m_memk[k][m_mar[k]];
                end
            end else begin
                if (!m_wr[k]) begin
                    m_mdr[k]  = '0;
                    m_mdrk[k] = 1'b1;
                end
                m_err[k] = 1'b1;
            end
            m_done[k] = 1'b1;
            m_rem[k]  = -1;
        end else begin
            if (marin[k]) m_mar[k] = bus[k][8:0];
            if (mdrin[k]) begin
                m_mdr[k]  = bus[k];
                m_mdrk[k] = 1'b1;
            end
            if (rd[k] && wr[k]) begin
                m_err[k] = 1'b1;
            end else if (rd[k] || wr[k]) begin
                m_wr[k]  = wr[k];
                m_rem[k] = c_ws[k];
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d busy", k), 32'(busy_o[k]), 32'(m_rem[k] >= 0));
            chk($sformatf("d%0d done", k), 32'(done_o[k]), 32'(m_done[k]));
            chk($sformatf("d%0d err", k),  32'(err_o[k]),  32'(m_err[k]));
            chk($sformatf("d%0d mar", k),  32'(mar_o[k]),  32'(m_mar[k]));
            if (m_mdrk[k]) chk($sformatf("d%0d mdr", k), mdr_o[k], m_mdr[k]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (!clear) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_all();
        marin = '0;
        mdrin = '0;
        rd    = '0;
        wr    = '0;
    endtask

    task automatic do_clear();
        #2;
        clear = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_all();
        @(posedge clock);
        #1;
        check_all();
        #2;
        clear = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        marin = '0; mdrin = '0; rd = '0; wr = '0; bus = '0;
        clear = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 512; a++) m_memk[k][a] = 1'b0;
            model_reset(k);
        end
        #2;
        check_all();
        @(posedge clock);
        #1;
        clear = 1'b0;
        check_all();

        // No wait states: store then load back through MDR
        bus[0] = 32'h1234_5678; mdrin[0] = 1'b1; step();
        bus[0] = 32'd5; marin[0] = 1'b1; wr[0] = 1'b1; step();
        chk("t1 busy after request", 32'(busy_o[0]), 32'd1);
        step();
        chk("t1 write done", 32'(done_o[0]), 32'd1);
        bus[0] = 32'd0; mdrin[0] = 1'b1; step();
        chk("t1 mdr cleared", mdr_o[0], 32'd0);
        rd[0] = 1'b1; steps(2);
        chk("t1 read data", mdr_o[0], 32'h1234_5678);

        // Read accepted in the done cycle of a write
        bus[0] = 32'hCAFE_F00D; mdrin[0] = 1'b1; step();
        bus[0] = 32'd6; marin[0] = 1'b1; wr[0] = 1'b1; step();
        step();
        chk("t6 write done", 32'(done_o[0]), 32'd1);
        rd[0] = 1'b1; step();
        chk("t6 back-to-back busy", 32'(busy_o[0]), 32'd1);
        step();
        chk("t6 read data", mdr_o[0], 32'hCAFE_F00D);

        // Three wait states: busy 4 cycles, MAR frozen while busy
        bus[1] = 32'd5; marin[1] = 1'b1; rd[1] = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            chk("t2 busy", 32'(busy_o[1]), 32'd1);
            bus[1] = 32'd7; marin[1] = 1'b1; step();
        end
        chk("t2 busy 4th", 32'(busy_o[1]), 32'd1);
        step();
        chk("t2 done at N+4", 32'(done_o[1]), 32'd1);
        chk("t2 mar frozen", 32'(mar_o[1]), 32'd5);

        // Simultaneous Read and Write on both units
        rd = 2'b11; wr = 2'b11; step();
        chk("t3 err d0", 32'(err_o[0]), 32'd1);
        chk("t3 err d1", 32'(err_o[1]), 32'd1);
        step();
        chk("t3 err pulse d0", 32'(err_o[0]), 32'd0);

        // Out-of-range accesses on the 500-word unit, plus the last legal word
        bus[1] = 32'd509; marin[1] = 1'b1; rd[1] = 1'b1; steps(5);
        chk("t4 oor read done", 32'(done_o[1]), 32'd1);
        chk("t4 oor read err", 32'(err_o[1]), 32'd1);
        chk("t4 oor read mdr", mdr_o[1], 32'd0);
        bus[1] = 32'h0BAD_BEEF; mdrin[1] = 1'b1; step();
        bus[1] = 32'd505; marin[1] = 1'b1; wr[1] = 1'b1; steps(5);
        chk("t4 oor write err", 32'(err_o[1]), 32'd1);
        bus[1] = 32'd499; marin[1] = 1'b1; wr[1] = 1'b1; steps(5);
        chk("t4 edge write err", 32'(err_o[1]), 32'd0);
        bus[1] = 32'd0; mdrin[1] = 1'b1; step();
        rd[1] = 1'b1; steps(5);
        chk("t4 edge read", mdr_o[1], 32'h0BAD_BEEF);

        // Clear during a pending write leaves RAM untouched
        bus[1] = 32'hAA; mdrin[1] = 1'b1; step();
        bus[1] = 32'd9; marin[1] = 1'b1; wr[1] = 1'b1; steps(5);
        bus[1] = 32'h55; mdrin[1] = 1'b1; step();
        bus[1] = 32'd9; marin[1] = 1'b1; wr[1] = 1'b1; step();
        step();
        do_clear();
        chk("t5 busy cleared", 32'(busy_o[1]), 32'd0);
        chk("t5 mdr cleared", mdr_o[1], 32'd0);
        bus[1] = 32'd9; marin[1] = 1'b1; rd[1] = 1'b1; steps(5);
        chk("t5 ram kept", mdr_o[1], 32'hAA);

        // Randomized traffic against the reference
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] v;
                v = $urandom;
                v[8:0] = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7))
                                                     : 9'($urandom_range(495, 511));
                bus[k]   = v;
                marin[k] = ($urandom_range(0, 3) == 0);
                mdrin[k] = ($urandom_range(0, 3) == 0);
                rd[k]    = ($urandom_range(0, 4) == 0);
                wr[k]    = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 99) == 0) begin
                marin = '0; mdrin = '0; rd = '0; wr = '0;
                do_clear();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
